// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Multi-layer, fully-connected inference core built around one signed MAC.
// A weight RAM holds LAYER_DEPTH layers of LAYER_SIZE x LAYER_SIZE weights.
// The core streams in one input vector and runs every layer back to back.
// Two activation buffers are used in ping-pong fashion. The core then
// streams out the final layer vector.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   w_we/w_layer/w_row/w_col    weight write port. Accepted only in IDLE.
//   w_data                      Out-of-range indices are dropped.
//   start                       single-cycle run request, sampled in IDLE only
//   busy                        high from start acceptance to last output handshake
//   x_valid/x_ready/x_data      input vector stream, element 0 first
//   y_valid/y_ready/y_data      output vector stream, element 0 first
//   y_last                      marks the final output element
//   done                        one-cycle pulse after the last output handshake
//   state_dbg                   current FSM state, for observation only
//
// Handshake: an element moves on a rising edge where valid and ready are both 1.
// The source holds valid and data stable until that edge.
// A ready signal never depends combinationally on valid.
//
// Build option: define NN_RELU_EN to clamp negative write-back values to 0.
module nn_layer_sequencer #(
  parameter int LAYER_SIZE  = 3,
  parameter int LAYER_DEPTH = 2,
  parameter int BIT_SIZE    = 8,
  parameter int FRAC_BITS   = 0,
  localparam int LW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1,
  localparam int NW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_we,
  input  logic [LW-1:0]       w_layer,
  input  logic [NW-1:0]       w_row,
  input  logic [NW-1:0]       w_col,
  input  logic [BIT_SIZE-1:0] w_data,
  input  logic                start,
  output logic                busy,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [BIT_SIZE-1:0] x_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [BIT_SIZE-1:0] y_data,
  output logic                y_last,
  output logic                done,
  output logic [2:0]          state_dbg
);
  localparam int PW    = 2 * BIT_SIZE;
  localparam int AW    = 2 * BIT_SIZE + $clog2(LAYER_SIZE) + 1;
  localparam int WORDS = LAYER_DEPTH * LAYER_SIZE * LAYER_SIZE;
  localparam int AD    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(LAYER_SIZE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LAYER_DEPTH - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BIT_SIZE+1){1'b0}}, {(BIT_SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BIT_SIZE+1){1'b1}}, {(BIT_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_OUT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d, x_ready_q, x_ready_d;
  logic                  y_valid_q, y_valid_d, y_last_q, y_last_d, done_q, done_d;
  logic [BIT_SIZE-1:0]   y_data_q, y_data_d;
  logic [LW-1:0]         l_q, l_d;
  logic [NW-1:0]         j_q, j_d, i_q, i_d, k_q, k_d, k_nxt;
  logic                  sel_q, sel_d;   // selects which buffer feeds the MAC
  logic signed [AW-1:0]  acc_q, acc_d, acc_sh;
  logic [BIT_SIZE-1:0]   act_q [2][LAYER_SIZE];
  logic [BIT_SIZE-1:0]   act_d [2][LAYER_SIZE];

  // Weight RAM: no reset, so weights survive a reset that aborts a run.
  logic [BIT_SIZE-1:0]   w_mem [WORDS];
  logic                  w_ok;
  logic [AD-1:0]         w_waddr, w_raddr;
  logic [BIT_SIZE-1:0]   w_rd;

  assign w_ok    = w_we && (state_q == S_IDLE) && (int'(w_layer) < LAYER_DEPTH) &&
                   (int'(w_row) < LAYER_SIZE) && (int'(w_col) < LAYER_SIZE);
  assign w_waddr = AD'(int'(w_layer) * LAYER_SIZE * LAYER_SIZE + int'(w_row) * LAYER_SIZE + int'(w_col));
  assign w_raddr = AD'(int'(l_q) * LAYER_SIZE * LAYER_SIZE + int'(j_q) * LAYER_SIZE + int'(i_q));
  assign w_rd    = w_mem[w_raddr];

  always_ff @(posedge clk) begin
    if (w_ok) w_mem[w_waddr] <= w_data;
  end

  // MAC datapath
  logic signed [PW-1:0]       prod;
  logic signed [AW-1:0]       prod_ext;
  logic [BIT_SIZE-1:0]        wb_val;

  assign prod     = $signed(w_rd) * $signed(act_q[sel_q][i_q]);
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign acc_sh   = acc_q >>> FRAC_BITS;
  assign k_nxt    = k_q + 1'b1;

  always_comb begin
    if (acc_sh > SAT_MAX)      wb_val = SAT_MAX[BIT_SIZE-1:0];
    else if (acc_sh < SAT_MIN) wb_val = SAT_MIN[BIT_SIZE-1:0];
    else                       wb_val = acc_sh[BIT_SIZE-1:0];
`ifdef NN_RELU_EN
    if (wb_val[BIT_SIZE-1]) wb_val = '0;
`else
`endif
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    x_ready_d = x_ready_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    y_data_d  = y_data_q;
    done_d    = 1'b0;
    l_d       = l_q;
    j_d       = j_q;
    i_d       = i_q;
    k_d       = k_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    act_d     = act_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          x_ready_d = 1'b1;
          i_d       = '0;
          sel_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (x_valid) begin
          act_d[sel_q][i_q] = x_data;
          if (i_q == N_LAST) begin
            state_d   = S_MAC;
            x_ready_d = 1'b0;
            i_d       = '0;
            j_d       = '0;
            l_d       = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        // i=0 restarts the accumulation for a new output node
        acc_d = ((i_q == '0) ? '0 : acc_q) + prod_ext;
        if (i_q == N_LAST) begin
          state_d = S_WB;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_WB: begin
        act_d[~sel_q][j_q] = wb_val;
        if (j_q != N_LAST) begin
          j_d     = j_q + 1'b1;
          state_d = S_MAC;
        end else if (l_q != L_LAST) begin
          l_d     = l_q + 1'b1;
          j_d     = '0;
          sel_d   = ~sel_q;
          state_d = S_MAC;
        end else begin
          // Element 0 was written by an earlier write-back, so it can be
          // registered now without a bypass from wb_val.
          state_d   = S_OUT;
          y_valid_d = 1'b1;
          y_data_d  = act_q[~sel_q][0];
          y_last_d  = 1'b0;
          k_d       = '0;
        end
      end
      S_OUT: begin
        if (y_ready) begin
          if (k_q == N_LAST) begin
            state_d   = S_DONE;
            y_valid_d = 1'b0;
            y_last_d  = 1'b0;
            y_data_d  = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            k_d      = k_nxt;
            y_data_d = act_q[~sel_q][k_nxt];
            y_last_d = (k_nxt == N_LAST);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_data_q  <= '0;
      done_q    <= 1'b0;
      l_q       <= '0;
      j_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      sel_q     <= 1'b0;
      acc_q     <= '0;
      for (int b = 0; b < 2; b++)
        for (int n = 0; n < LAYER_SIZE; n++)
          act_q[b][n] <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      x_ready_q <= x_ready_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      y_data_q  <= y_data_d;
      done_q    <= done_d;
      l_q       <= l_d;
      j_q       <= j_d;
      i_q       <= i_d;
      k_q       <= k_d;
      sel_q     <= sel_d;
      acc_q     <= acc_d;
      act_q     <= act_d;
    end
  end

  assign busy      = busy_q;
  assign x_ready   = x_ready_q;
  assign y_valid   = y_valid_q;
  assign y_last    = y_last_q;
  assign y_data    = y_data_q;
  assign done      = done_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
module tb_nn_layer_sequencer;
  localparam int N   = 3;
  localparam int D   = 2;
  localparam int B   = 8;
  localparam int F   = 2;
  localparam int LW  = 1;
  localparam int NW  = 2;
  localparam int LAT = D * N * (N + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          w_we = 1'b0;
  logic [LW-1:0] w_layer = '0;
  logic [NW-1:0] w_row = '0, w_col = '0;
  logic [B-1:0]  w_data = '0;
  logic          start = 1'b0;
  logic          busy, x_ready, y_valid, y_last, done;
  logic          x_valid = 1'b0;
  logic [B-1:0]  x_data = '0;
  logic          y_ready = 1'b0;
  logic [B-1:0]  y_data;
  logic [2:0]    state_dbg;

  nn_layer_sequencer #(.LAYER_SIZE(N), .LAYER_DEPTH(D), .BIT_SIZE(B), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_layer(w_layer), .w_row(w_row), .w_col(w_col),
    .w_data(w_data), .start(start), .busy(busy), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last(y_last), .done(done), .state_dbg(state_dbg)
  );

  // reference model state and scoreboard
  int           w_m [D][N][N];
  int           x_vec [N];
  logic [B-1:0] exp_q [$];
  int           n_vec = 0;
  int           n_bad = 0;

  // Network evaluated with plain integer arithmetic.
  function automatic void model_run();
    longint a [N];
    longint b [N];
    longint acc;
    for (int i = 0; i < N; i++) a[i] = x_vec[i];
    for (int l = 0; l < D; l++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(w_m[l][j][i]) * a[i];
        acc = acc >>> F;
        if (acc > (2 ** (B - 1)) - 1) acc = (2 ** (B - 1)) - 1;
        else if (acc < -(2 ** (B - 1))) acc = -(2 ** (B - 1));
`ifdef NN_RELU_EN
        if (acc < 0) acc = 0;
`endif
        b[j] = acc;
      end
      a = b;
    end
    exp_q.delete();
    for (int j = 0; j < N; j++) exp_q.push_back(B'(a[j]));
  endfunction

  // driver tasks: entered and left just after a falling edge
  task automatic write_w(input int l, input int j, input int i, input int v, input bit upd);
    w_we = 1'b1; w_layer = LW'(l); w_row = NW'(j); w_col = NW'(i); w_data = B'(v);
    @(negedge clk);
    w_we = 1'b0;
    if (upd) w_m[l][j][i] = v;
  endtask

  task automatic load_weights();
    for (int l = 0; l < D; l++)
      for (int j = 0; j < N; j++)
        for (int i = 0; i < N; i++)
          write_w(l, j, i, w_m[l][j][i], 1'b1);
  endtask

  // mode 0: plain run, 1: hold y_ready low 5 cycles on element 0,
  // 2: weight writes and start pulses while computing, 3: reset in MAC cycle 3
  task automatic run_vec(input string name, input int mode);
    int idx, cyc, k, hold;
    bit hs;
    model_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || x_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_start: busy=%b x_ready=%b, required 1 1", name, busy, x_ready);
    end
    idx = 0; cyc = 0;
    while (idx < N && cyc < 200) begin
      x_valid = ($urandom_range(0, 3) != 0);
      x_data  = B'(x_vec[idx]);
      hs = x_valid && x_ready;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    x_valid = 1'b0;
    n_vec++;
    if (idx != N) begin
      n_bad++;
      $display("FAIL %s_load: %0d elements accepted, required %0d", name, idx, N);
      return;
    end
    k = 0;
    while (y_valid !== 1'b1 && k < LAT + 50) begin
      w_we  = (mode == 2 && k >= 1 && k <= N);
      start = (mode == 2 && k >= 1 && k <= N);
      if (mode == 2 && k >= 1 && k <= N) begin
        w_layer = '0; w_row = NW'(k - 1); w_col = NW'(k - 1); w_data = 8'd100;
      end
      if (mode == 3 && k == 2) rst = 1'b1;
      @(negedge clk);
      k++;
      rst = 1'b0;
      w_we = 1'b0;
      start = 1'b0;
      if (mode == 3 && k == 3) begin
        for (int c = 0; c < 4; c++) begin
          n_vec++;
          if (busy !== 1'b0 || done !== 1'b0 || x_ready !== 1'b0 || y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_abort: busy=%b done=%b x_ready=%b y_valid=%b, required 0 0 0 0",
                     name, busy, done, x_ready, y_valid);
          end
          @(negedge clk);
        end
        return;
      end
    end
    n_vec++;
    if (k != LAT) begin
      n_bad++;
      $display("FAIL %s_latency: %0d cycles, required %0d", name, k, LAT);
    end
    cyc = 0; hold = (mode == 1) ? 5 : 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      n_vec++;
      if (y_valid !== 1'b1 || busy !== 1'b1 || y_data !== exp_q[0] ||
          y_last !== (exp_q.size() == 1)) begin
        n_bad++;
        $display("FAIL %s_y[%0d]: valid=%b busy=%b data=%0d last=%b, required 1 1 %0d %b", name,
                 N - exp_q.size(), y_valid, busy, $signed(y_data), y_last,
                 $signed(exp_q[0]), exp_q.size() == 1);
      end
      if (hold > 0) begin
        y_ready = 1'b0;
        hold--;
      end else begin
        y_ready = ($urandom_range(0, 2) != 0);
      end
      hs = y_ready && y_valid;
      @(negedge clk);
      cyc++;
      if (hs) void'(exp_q.pop_front());
    end
    y_ready = 1'b0;
    n_vec++;
    if (exp_q.size() != 0 || done !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: left=%0d done=%b busy=%b y_valid=%b, required 0 1 0 0",
               name, exp_q.size(), done, busy, y_valid);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_pulse: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || x_ready !== 1'b0 || y_valid !== 1'b0 || y_last !== 1'b0 ||
        done !== 1'b0 || y_data !== '0) begin
      n_bad++;
      $display("FAIL reset: busy=%b x_ready=%b y_valid=%b y_last=%b done=%b y_data=%h, required all 0",
               busy, x_ready, y_valid, y_last, done, y_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    for (int l = 0; l < D; l++)
      for (int j = 0; j < N; j++)
        for (int i = 0; i < N; i++)
          w_m[l][j][i] = (i == j) ? (1 << F) : 0;
    load_weights();
    x_vec = '{5, -3, 17};
    run_vec("identity", 1);
  endtask

  task automatic test_saturation();
    for (int l = 0; l < D; l++)
      for (int j = 0; j < N; j++)
        for (int i = 0; i < N; i++)
          w_m[l][j][i] = 127;
    load_weights();
    x_vec = '{100, 100, 100};
    run_vec("sat_pos", 0);
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        write_w(1, j, i, -127, 1'b1);
    run_vec("sat_neg", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int l = 0; l < D; l++)
        for (int j = 0; j < N; j++)
          for (int i = 0; i < N; i++)
            w_m[l][j][i] = (it % 2 == 0) ? int'($urandom_range(0, 255)) - 128
                                         : int'($urandom_range(0, 32)) - 16;
      load_weights();
      for (int i = 0; i < N; i++) x_vec[i] = int'($urandom_range(0, 255)) - 128;
      run_vec("random", 0);
    end
  endtask

  task automatic test_busy_ignore();
    for (int l = 0; l < D; l++)
      for (int j = 0; j < N; j++)
        for (int i = 0; i < N; i++)
          w_m[l][j][i] = (i == j) ? (1 << F) : int'($urandom_range(0, 4)) - 2;
    load_weights();
    x_vec = '{20, 30, 25};
    run_vec("busy_ignore", 2);
    for (int j = 0; j < N; j++) write_w(0, j, j, 100, 1'b1);
    run_vec("new_weights", 0);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < N; i++) write_w(0, 3, i, 99, 1'b0);
    for (int j = 0; j < N; j++) write_w(1, j, 3, -99, 1'b0);
    write_w(1, 3, 3, 77, 1'b0);
    x_vec = '{-7, 11, 3};
    run_vec("out_of_range", 0);
  endtask

  task automatic test_reset_mid();
    x_vec = '{9, -12, 40};
    run_vec("reset_mid", 3);
    run_vec("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_random();
    test_busy_ignore();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
